// File: rtl/burst_proc_pkg.sv
// Shared types and constants for the burst processor: FSM state encoding,
// operation encodings and the accumulator identity selection.
package burst_proc_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  // Reduction operation, latched when a burst starts.
  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_XOR = 2'd1,
    OP_MAX = 2'd2,
    OP_MIN = 2'd3
  } op_t;

  // Identity values are all-zeros or all-ones at any width, so only the
  // replicated bit is stored here; the user replicates it to WIDTH.
  localparam logic IDENT_ZERO = 1'b0;
  localparam logic IDENT_ONES = 1'b1;

  // Bit to replicate across the accumulator when a burst starts.
  function automatic logic identity_bit(input op_t op);
    return (op == OP_MIN) ? IDENT_ONES : IDENT_ZERO;
  endfunction

endpackage : burst_proc_pkg

// File: rtl/burst_proc_alu.sv
// Combinational reduction step: folds one input word into the running
// accumulator according to the latched operation.
module burst_proc_alu
  import burst_proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_acc
);

  // Select the next accumulator value; SUM drops the carry out.
  always_comb begin
    // NOTE: default assignment first so every path drives next_acc and no latch is inferred.
    next_acc = acc;
    case (op)
      OP_SUM:  next_acc = acc + data_in;
      OP_XOR:  next_acc = acc ^ data_in;
      OP_MAX:  next_acc = (data_in > acc) ? data_in : acc;
      OP_MIN:  next_acc = (data_in < acc) ? data_in : acc;
      default: next_acc = acc;
    endcase
  end

endmodule : burst_proc_alu

// File: rtl/burst_proc_fsm.sv
// Burst reduction controller. Collects DEPTH words, reduces them with the
// operation latched at start, presents the result until it is consumed,
// and bails out to IDLE on abort or on an inter-word timeout.
module burst_proc_fsm
  import burst_proc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic                       abort,
  input  logic                       data_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       out_ready,
  output logic                       ready,
  output logic                       processing,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       error
);

  localparam int CW = $clog2(DEPTH + 1);
  // The idle counter only ever reaches TIMEOUT-1 before the timeout fires.
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] next_acc;
  logic [IW-1:0]    idle_cnt;

  burst_proc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op       (op_q),
    .acc      (acc),
    .data_in  (data_in),
    .next_acc (next_acc)
  );

  // Controller, counters, accumulator and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the accumulator and result are reset explicitly so no stale data is visible after reset.
      state      <= S_IDLE;
      op_q       <= OP_SUM;
      acc        <= '0;
      idle_cnt   <= '0;
      data_out   <= '0;
      count      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      ready      <= 1'b1;
      processing <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      done  <= 1'b0;
      error <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_COLLECT;
            op_q       <= op_t'(op);
            acc        <= {WIDTH{identity_bit(op_t'(op))}};
            count      <= '0;
            idle_cnt   <= '0;
            ready      <= 1'b0;
            processing <= 1'b1;
          end
        end

        S_COLLECT: begin
          if (abort) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            processing <= 1'b0;
          end else if (data_valid) begin
            acc      <= next_acc;
            count    <= count + 1'b1;
            idle_cnt <= '0;
            if (count == LAST_WORD) begin
              // Final word: publish the reduced value directly from the ALU.
              state      <= S_RESULT;
              data_out   <= next_acc;
              processing <= 1'b0;
              out_valid  <= 1'b1;
            end
          end else if (idle_cnt == LAST_IDLE) begin
            state      <= S_IDLE;
            error      <= 1'b1;
            ready      <= 1'b1;
            processing <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_RESULT: begin
          if (abort) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            ready     <= 1'b1;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          ready      <= 1'b1;
          processing <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule : burst_proc_fsm
